// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM controller: main FSM states and the
// datapath mux selects that the control unit drives.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] OP_DP      = 2'b00;
    localparam logic [1:0] OP_MEM     = 2'b01;
    localparam logic [1:0] OP_BR      = 2'b10;
    localparam logic [1:0] OP_ILL     = 2'b11;

endpackage

// File: rtl/mc_main_fsm.sv
// Main control FSM of the multicycle ARM: state register, next-state logic and
// a state decoder producing the datapath enables and mux selects.
module mc_main_fsm
    import arm_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       irwrite,
    output logic       nextpc,
    output logic       adrsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic       regw,
    output logic       memw,
    output logic       branch,
    output logic       aluop,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q, state_d;

    // Only the I and S/L bits steer the main FSM.
    logic unused_funct;
    assign unused_funct = ^funct[4:1];

    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Outputs are decoded straight from the state so that reset silences them
    // in the same cycle it is asserted, without waiting for an edge.
    always_comb begin
        irwrite    = 1'b0;
        nextpc     = 1'b0;
        adrsrc     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_REG;
        resultsrc  = RES_ALUOUT;
        regw       = 1'b0;
        memw       = 1'b0;
        branch     = 1'b0;
        aluop      = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    irwrite   = mem_ready;
                    nextpc    = mem_ready;
                    alusrca   = 1'b1;
                    alusrcb   = SRCB_FOUR;
                    resultsrc = RES_ALU;
                end
                S_DECODE: begin
                    alusrca   = 1'b1;
                    alusrcb   = SRCB_FOUR;
                    resultsrc = RES_ALU;
                    if (op == OP_ILL) begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                S_MEMADR: begin
                    alusrcb = SRCB_IMM;
                end
                S_MEMREAD: begin
                    adrsrc    = 1'b1;
                    resultsrc = RES_ALUOUT;
                end
                S_MEMWB: begin
                    resultsrc  = RES_DATA;
                    regw       = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWRITE: begin
                    adrsrc     = 1'b1;
                    resultsrc  = RES_ALUOUT;
                    memw       = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXECR: begin
                    alusrcb = SRCB_REG;
                    aluop   = 1'b1;
                end
                S_EXECI: begin
                    alusrcb = SRCB_IMM;
                    aluop   = 1'b1;
                end
                S_ALUWB: begin
                    resultsrc  = RES_ALUOUT;
                    regw       = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alusrcb    = SRCB_IMM;
                    resultsrc  = RES_ALU;
                    branch     = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Bench for mc_main_fsm: random instruction streams with random memory stalls,
// checked cycle by cycle against an instruction-level trace model.
module tb_mc_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       irwrite, nextpc, adrsrc, alusrca;
    logic [1:0] alusrcb, resultsrc;
    logic       regw, memw, branch, aluop, instr_done, illegal;
    logic [3:0] state;

    mc_main_fsm dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
        .irwrite(irwrite), .nextpc(nextpc), .adrsrc(adrsrc), .alusrca(alusrca),
        .alusrcb(alusrcb), .resultsrc(resultsrc), .regw(regw), .memw(memw),
        .branch(branch), .aluop(aluop), .instr_done(instr_done),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4;
    localparam int MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9;
    localparam int C_DPR = 0, C_DPI = 1, C_LDR = 2, C_STR = 3, C_B = 4, C_ILL = 5;

    int n_tests = 0;
    int n_fail  = 0;
    int done_seen = 0;
    int regw_seen = 0;
    int memw_seen = 0;

    logic [13:0] obs;
    assign obs = {irwrite, nextpc, adrsrc, alusrca, alusrcb, resultsrc,
                  regw, memw, branch, aluop, instr_done, illegal};

    // Expected output vector for a state, from the per-state output table.
    function automatic logic [13:0] exp_vec(int st, logic mr, logic ill);
        logic irw = 0, npc = 0, adr = 0, sa = 0, rw = 0, mw = 0, br = 0;
        logic ao = 0, dn = 0, il = 0;
        logic [1:0] sb = 2'b00, rs = 2'b00;
        case (st)
            FETCH:    begin irw = mr; npc = mr; sa = 1; sb = 2'b10; rs = 2'b10; end
            DECODE:   begin sa = 1; sb = 2'b10; rs = 2'b10; il = ill; dn = ill; end
            MEMADR:   begin sb = 2'b01; end
            MEMREAD:  begin adr = 1; end
            MEMWB:    begin rs = 2'b01; rw = 1; dn = 1; end
            MEMWRITE: begin adr = 1; mw = 1; dn = mr; end
            EXECR:    begin ao = 1; end
            EXECI:    begin sb = 2'b01; ao = 1; end
            ALUWB:    begin rw = 1; dn = 1; end
            BRANCH:   begin sb = 2'b01; rs = 2'b10; br = 1; dn = 1; end
            default:  ;
        endcase
        return {irw, npc, adr, sa, sb, rs, rw, mw, br, ao, dn, il};
    endfunction

    task automatic step(string name, int st, logic mr, logic [1:0] op_i, logic [5:0] funct_i);
        @(negedge clk);
        mem_ready = mr;
        op        = op_i;
        funct     = funct_i;
        #1;
        n_tests++;
        if (state !== st[3:0] || obs !== exp_vec(st, mr, op_i == 2'b11)) begin
            n_fail++;
            $display("FAIL %s: state=%0d outs=%b, required state=%0d outs=%b",
                     name, state, obs, st, exp_vec(st, mr, op_i == 2'b11));
        end
        if (instr_done === 1'b1) done_seen++;
        if (regw === 1'b1) regw_seen++;
        if (memw === 1'b1) memw_seen++;
    endtask

    // Builds the expected cycle trace of one instruction from its class and
    // stall counts, then runs it, driving mem_ready as the trace dictates.
    task automatic run_instr(string name, int cls, int fs, int ms, logic [5:0] funct_i);
        int sq[$];
        logic mq[$];
        logic [1:0] op_i;
        int d0, r0, m0;
        case (cls)
            C_DPR, C_DPI: op_i = 2'b00;
            C_LDR, C_STR: op_i = 2'b01;
            C_B:          op_i = 2'b10;
            default:      op_i = 2'b11;
        endcase
        repeat (fs) begin sq.push_back(FETCH); mq.push_back(1'b0); end
        sq.push_back(FETCH);  mq.push_back(1'b1);
        sq.push_back(DECODE); mq.push_back(1'($urandom));
        case (cls)
            C_DPR: begin sq.push_back(EXECR); mq.push_back(1'($urandom));
                         sq.push_back(ALUWB); mq.push_back(1'($urandom)); end
            C_DPI: begin sq.push_back(EXECI); mq.push_back(1'($urandom));
                         sq.push_back(ALUWB); mq.push_back(1'($urandom)); end
            C_LDR: begin sq.push_back(MEMADR); mq.push_back(1'($urandom));
                         repeat (ms) begin sq.push_back(MEMREAD); mq.push_back(1'b0); end
                         sq.push_back(MEMREAD); mq.push_back(1'b1);
                         sq.push_back(MEMWB); mq.push_back(1'($urandom)); end
            C_STR: begin sq.push_back(MEMADR); mq.push_back(1'($urandom));
                         repeat (ms) begin sq.push_back(MEMWRITE); mq.push_back(1'b0); end
                         sq.push_back(MEMWRITE); mq.push_back(1'b1); end
            C_B:   begin sq.push_back(BRANCH); mq.push_back(1'($urandom)); end
            default: ;
        endcase
        d0 = done_seen; r0 = regw_seen; m0 = memw_seen;
        foreach (sq[i]) step(name, sq[i], mq[i], op_i, funct_i);
        n_tests++;
        if (done_seen - d0 != 1) begin
            n_fail++;
            $display("FAIL %s_done_count: got %0d pulses, required 1", name, done_seen - d0);
        end
        n_tests++;
        if (regw_seen - r0 != ((cls == C_DPR || cls == C_DPI || cls == C_LDR) ? 1 : 0) ||
            memw_seen - m0 != ((cls == C_STR) ? ms + 1 : 0)) begin
            n_fail++;
            $display("FAIL %s_write_count: regw=%0d memw=%0d cycles", name,
                     regw_seen - r0, memw_seen - m0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; op = 2'b11; funct = '1;
        #1;
        n_tests++;
        if (state !== 4'd0 || obs !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d outs=%b, required 0 and 0", state, obs);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_tests++;
        if (state !== 4'd0 || obs !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_held: state=%0d outs=%b, required 0 and 0", state, obs);
        end
        mem_ready = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_directed();
        run_instr("add_imm", C_DPI, 0, 0, 6'b101000);
        run_instr("ldr_stall2", C_LDR, 0, 2, 6'b011001);
        run_instr("str_stall1", C_STR, 0, 1, 6'b011000);
        run_instr("branch", C_B, 0, 0, 6'b000000);
        run_instr("illegal", C_ILL, 0, 0, 6'b111111);
        run_instr("fetch_stall3", C_DPR, 3, 0, 6'b001010);
    endtask

    task automatic test_reset_mid_write();
        step("rst_fetch", FETCH, 1'b1, 2'b01, 6'b000000);
        step("rst_decode", DECODE, 1'b0, 2'b01, 6'b000000);
        step("rst_memadr", MEMADR, 1'b0, 2'b01, 6'b000000);
        step("rst_memwrite", MEMWRITE, 1'b0, 2'b01, 6'b000000);
        reset = 1'b1;
        #1;
        n_tests++;
        if (state !== 4'd0 || memw !== 1'b0 || obs !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_async: state=%0d memw=%b outs=%b, required 0 0 0", state, memw, obs);
        end
        @(negedge clk); mem_ready = 1'b1; #1;
        n_tests++;
        if (state !== 4'd0 || obs !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_abort: state=%0d outs=%b, required 0 and 0", state, obs);
        end
        mem_ready = 1'b0;
        reset = 1'b0;
        step("post_reset_wait", FETCH, 1'b0, 2'b00, 6'b000000);
        run_instr("post_reset_add", C_DPI, 0, 0, 6'b100100);
    endtask

    task automatic test_random();
        for (int unsigned k = 0; k < 40; k++) begin
            int cls;
            logic [5:0] f;
            cls = int'($urandom_range(0, 5));
            f = 6'($urandom);
            case (cls)
                C_DPR: f[5] = 1'b0;
                C_DPI: f[5] = 1'b1;
                C_LDR: f[0] = 1'b1;
                C_STR: f[0] = 1'b0;
                default: ;
            endcase
            run_instr("random", cls, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), f);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule

// File: doc/mc_main_fsm.md
MC_MAIN_FSM -- requirements
Module: mc_main_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port op, input, 2 bits: Instr[27:26], sampled from the instruction register.
REQ-004 SHALL have port funct, input, 6 bits: Instr[25:20]. Bit 5 is I (immediate). Bit 0 is S/L.
REQ-005 SHALL have port mem_ready, input, 1 bit: the shared instruction/data memory has completed the current access.
REQ-006 SHALL have port irwrite, output, 1 bit: load the instruction register.
REQ-007 SHALL have port nextpc, output, 1 bit: PC register enable (unconditional PC+4 update).
REQ-008 SHALL have port adrsrc, output, 1 bit: memory address select. 0 = PC, 1 = ALU result.
REQ-009 SHALL have port alusrca, output, 1 bit: 0 = register rn, 1 = PC.
REQ-010 SHALL have port alusrcb, output, 2 bits: 00 = register, 01 = extended immediate, 10 = constant 4.
REQ-011 SHALL have port resultsrc, output, 2 bits: 00 = ALU output register, 01 = data register, 10 = ALU result.
REQ-012 SHALL have ports regw, memw, branch and aluop, outputs, 1 bit each: unconditioned enables for the existing condition logic and ALU decoder.
REQ-013 SHALL have port instr_done, output, 1 bit: single-cycle pulse in the last state of every instruction.
REQ-014 SHALL have port illegal, output, 1 bit: single-cycle pulse when DECODE sees op=11.
REQ-015 SHALL have port state, output, 4 bits: current state encoding, for debug.

Function
REQ-016 SHALL be a Moore FSM with these states:
- FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4
- MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9
REQ-017 SHALL leave every output not listed for a state at 0. The state output always equals the current encoding.
REQ-018 FETCH SHALL drive adrsrc=0, alusrca=1, alusrcb=10, resultsrc=10, aluop=0.
REQ-019 In FETCH, irwrite and nextpc SHALL equal mem_ready. FETCH→DECODE when mem_ready=1, else the FSM holds FETCH.
REQ-020 DECODE SHALL drive alusrca=1, alusrcb=10, resultsrc=10, so R15 reads as PC+8.
REQ-021 DECODE transitions SHALL be:
- op=01 → MEMADR
- op=00 with funct[5]=1 → EXECI
- op=00 with funct[5]=0 → EXECR
- op=10 → BRANCH
- op=11 → FETCH, with illegal=1 and instr_done=1
REQ-022 MEMADR SHALL drive alusrca=0, alusrcb=01, aluop=0. It goes to MEMREAD if funct[0]=1, else MEMWRITE.
REQ-023 MEMREAD SHALL drive adrsrc=1, resultsrc=00. It goes to MEMWB when mem_ready=1, else holds.
REQ-024 MEMWB SHALL drive resultsrc=01, regw=1, instr_done=1, then go to FETCH.
REQ-025 MEMWRITE SHALL drive adrsrc=1, resultsrc=00, memw=1 for every cycle in the state.
REQ-026 MEMWRITE SHALL assert instr_done and go to FETCH only in the cycle with mem_ready=1.
REQ-027 EXECR SHALL drive alusrca=0, alusrcb=00, aluop=1, then go to ALUWB.
REQ-028 EXECI SHALL drive alusrca=0, alusrcb=01, aluop=1, then go to ALUWB.
REQ-029 ALUWB SHALL drive resultsrc=00, regw=1, instr_done=1, then go to FETCH.
REQ-030 BRANCH SHALL drive alusrca=0, alusrcb=01, resultsrc=10, branch=1, instr_done=1, then go to FETCH.
REQ-031 Instruction latency in cycles with mem_ready held at 1 SHALL be: LDR 5, STR 4, data-processing 4, B 3.
REQ-032 Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE SHALL add exactly one cycle of latency.
REQ-033 An unused state encoding (10-15) SHALL go to FETCH on the next edge with all outputs 0.

Reset
REQ-034 reset SHALL force state=FETCH immediately and asynchronously, with no clock edge required.
REQ-035 While reset=1, every output SHALL be 0.
REQ-036 Assertion of reset in any state, including mid-MEMWRITE, SHALL abort the instruction. No further memw or regw is asserted.
REQ-037 After reset deasserts, the first edge with mem_ready=1 SHALL perform the first fetch.

Structure
REQ-038 The state enum typedef and the alusrcb/resultsrc encoding constants SHALL live in the shared package arm_mc_pkg.
REQ-039 The block SHALL have no sub-module. It contains a state register, next-state logic and an output decoder only.

Verification
REQ-040 ADD R1,R2,#5 (op=00, funct=101000) with mem_ready=1 → states 0,1,7,8. regw=1 and instr_done=1 only in cycle 4.
REQ-041 LDR (op=01, funct=011001) with mem_ready=0 for the first 2 cycles of MEMREAD → states 0,1,2,3,3,3,4. Total 7 cycles; regw pulses once.
REQ-042 STR (op=01, funct=011000) with mem_ready low for 1 cycle of MEMWRITE → memw=1 for 2 cycles, then state=0.
REQ-043 B (op=10) → branch=1 in cycle 3, then FETCH. op=11 → illegal=1 in cycle 2, then FETCH.
REQ-044 reset pulsed while in MEMWRITE → state=0 and memw=0 in the same cycle, before the next clock edge.
REQ-045 FETCH with mem_ready=0 for 3 cycles → irwrite=0 and nextpc=0 for 3 cycles. Both are 1 in cycle 4, then state=DECODE.
